// File: rtl/load_store_unit.sv
// Load/store unit: RV32I B/H/W loads and stores over a req/gnt + rvalid memory bus.
// Latency: accept at T, gnt at T+1, rvalid at T+2 -> rsp_valid at T+3; illegal access responds at T+1.
// Backpressure: req_ready only in IDLE; mem_req held stable until mem_gnt. LSU_MISALIGN_CHECK_EN enables the alignment check.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    // Wide enough to hold TIMEOUT_CYC-1 for any parameter value.
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 2);

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            req_illegal;
    logic [3:0]      be_w;
    logic [31:0]     wd_w;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_ext;
    logic            to_hit;

    // Classify the incoming request: reserved funct3, signed-less stores, optional misalignment.
    always_comb begin
        req_illegal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
            default:                                req_illegal = 1'b1;
        endcase
        if (req_we && req_funct3[2]) begin
            req_illegal = 1'b1;
        end
`ifdef LSU_MISALIGN_CHECK_EN
        if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
            req_illegal = 1'b1;
        end
`endif
    end

    // Store lane placement: byte enables and replicated write data (loads drive neither).
    always_comb begin
        be_w = 4'b0000;
        wd_w = 32'h0;
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    be_w = 4'b0001 << addr_q[1:0];
                    wd_w = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    be_w = 4'b0011 << {addr_q[1], 1'b0};
                    wd_w = {2{wdata_q[15:0]}};
                end
                default: begin
                    be_w = 4'b1111;
                    wd_w = wdata_q;
                end
            endcase
        end
    end

    // Load lane selection and sign/zero extension of the returned word.
    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Last permitted WAIT cycle; a zero TIMEOUT_CYC never expires.
    assign to_hit = (TIMEOUT_CYC != 0) &&
                    ({{(32-CW){1'b0}}, cnt_q} == TIMEOUT_CYC - 32'd1);

    // Next-state and datapath capture.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = req_illegal;
                    state_d  = req_illegal ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = we_q ? 32'h0 : ld_ext;
                    state_d = RESP;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs depend on state only, so bus fields are zero outside REQ.
    assign req_ready = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be    = mem_req ? be_w : 4'b0000;
    assign mem_wdata = mem_req ? wd_w : 32'h0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes.
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        sz = acc_size(f3);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((int'(addr[1:0]) % sz) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Lane offset of the access after dropping sub-size address bits.
    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = acc_size(f3);
        return (int'(addr[1:0]) / sz) * sz;
    endfunction

    // Drives one transaction with the given bus delays and checks every cycle against the model.
    task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
        bit          ill;
        int          sz, off;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd, mask, exp_addr;
        logic [73:0] got_bus, exp_bus;
        ill = model_illegal(we, f3, addr);
        sz  = acc_size(f3);
        off = lane_off(f3, addr);
        ebe = 4'b0000;
        ewd = 32'h0;
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                ewd[8*k +: 8] = wdata[8*(k % sz) +: 8];
                if (k >= off && k < off + sz) ebe[k] = 1'b1;
            end
        end
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
        erd  = (rdata >> (8*off)) & mask;
        if (sz < 4 && !f3[2] && erd[8*sz-1]) erd = erd | ~mask;
        if (we || ill) erd = 32'h0;
        exp_addr = addr & 32'hFFFF_FFFC;

        n_tests++;
        if (req_ready !== 1'b1)
            $display("FAIL %s ready_idle: got %b want 1", name, req_ready);
        if (req_ready !== 1'b1) n_fail++;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        step();
        req_valid = 1'b0; req_we = $urandom; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        if (!ill) begin
            for (int i = 0; i <= gnt_dly; i++) begin
                got_bus = {mem_req, mem_we, mem_be, mem_addr, mem_wdata, req_ready, rsp_valid};
                exp_bus = {1'b1, we, ebe, exp_addr, ewd, 1'b0, 1'b0};
                n_tests++;
                if (got_bus !== exp_bus) begin
                    n_fail++;
                    $display("FAIL %s req_cyc%0d: got %h want %h", name, i, got_bus, exp_bus);
                end
                mem_gnt = (i == gnt_dly); mem_rvalid = $urandom; mem_rdata = $urandom;
                step();
            end
            mem_gnt = 1'b0;
            for (int j = 0; j <= rv_dly; j++) begin
                n_tests++;
                if ({mem_req, rsp_valid, req_ready} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL %s wait_cyc%0d: got %b want 000", name, j, {mem_req, rsp_valid, req_ready});
                end
                mem_rvalid = (j == rv_dly);
                mem_rdata  = (j == rv_dly) ? rdata : $urandom;
                step();
            end
            mem_rvalid = 1'b0;
        end
        n_tests++;
        if ({rsp_valid, rsp_err, rsp_rdata, mem_req} !== {1'b1, ill, erd, 1'b0}) begin
            n_fail++;
            $display("FAIL %s resp: got v=%b e=%b d=%h req=%b want v=1 e=%b d=%h req=0",
                     name, rsp_valid, rsp_err, rsp_rdata, mem_req, ill, erd);
        end
        mem_rvalid = $urandom; mem_rdata = $urandom;
        step();
        mem_rvalid = 1'b0;
        n_tests++;
        if ({rsp_valid, req_ready, mem_req} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s back_idle: got %b want 010", name, {rsp_valid, req_ready, mem_req});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step(); step();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if ({req_ready, rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 104'h0}) begin
                n_fail++;
                $display("FAIL reset_cyc%0d: ready=%b rv=%b err=%b rd=%h req=%b we=%b be=%b a=%h wd=%h want ready=1 rest 0",
                         c, req_ready, rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
            end
            step();
        end
    endtask

    task automatic test_directed();
        run_txn("lw_basic", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        run_txn("lb_sign",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0);
        run_txn("lbu_zero", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 0);
        run_txn("sh_stall", 1'b1, 3'b001, 32'h22,  32'h1234ABCD, 32'h0, 3, 1);
        run_txn("lhu_hi",   1'b0, 3'b101, 32'h42,  32'h0, 32'hF00D8001, 1, 2);
        run_txn("sb_lane1", 1'b1, 3'b000, 32'h201, 32'hAABBCC5A, 32'h0, 0, 0);
        run_txn("f3_011",   1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 0, 0);
        run_txn("sbu_bad",  1'b1, 3'b100, 32'h300, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic test_misalign();
        run_txn("lw_mis",  1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0);
        run_txn("sh_mis",  1'b1, 3'b001, 32'h103, 32'h55AA7711, 32'h0, 1, 0);
        run_txn("lh_mis",  1'b0, 3'b001, 32'h105, 32'h0, 32'h9000ABCD, 0, 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 200; t++) begin
            run_txn("rand", 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, TO - 1)));
        end
    endtask

    task automatic test_timeout();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
        step();
        req_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int w = 0; w < int'(TO); w++) begin
            n_tests++;
            if ({rsp_valid, mem_req} !== 2'b00) begin
                n_fail++;
                $display("FAIL timeout_wait%0d: got %b want 00", w, {rsp_valid, mem_req});
            end
            step();
        end
        n_tests++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
            n_fail++;
            $display("FAIL timeout_resp: got v=%b e=%b d=%h want v=1 e=1 d=0", rsp_valid, rsp_err, rsp_rdata);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        for (int s = 0; s < 3; s++) begin
            step();
            n_tests++;
            if ({rsp_valid, rsp_err, rsp_rdata, mem_req, req_ready} !== {34'h0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL stray_rvalid%0d: got v=%b e=%b d=%h req=%b rdy=%b want idle",
                         s, rsp_valid, rsp_err, rsp_rdata, mem_req, req_ready);
            end
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
        step();
        req_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++;
        if ({req_ready, rsp_valid, mem_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy/rv/req=%b want 100", {req_ready, rsp_valid, mem_req});
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF0000;
        for (int s = 0; s < 3; s++) begin
            step();
            n_tests++;
            if ({req_ready, rsp_valid, mem_req} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_mid_after%0d: got %b want 100", s, {req_ready, rsp_valid, mem_req});
            end
        end
        mem_rvalid = 1'b0;
        run_txn("after_rst", 1'b0, 3'b000, 32'h502, 32'h0, 32'h00FE0000, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
